// File: rtl/fork_event_filter.sv
// Debounces the four UART detector bits and reports one fork event per armed junction.
// Optional build macro FORK_EVENT_COUNT_EN adds a saturating fork_count output.
module fork_event_filter #(
    parameter int TICK_DIV      = 100000,
    parameter int STABLE_CNT    = 20,
    parameter int HOLDOFF_TICKS = 500
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic [3:0] det_raw,
    input  logic       arm,
    output logic [3:0] det_stable,
    output logic       fork_pulse,
    output logic       fork_level,
    output logic       holdoff_active
`ifdef FORK_EVENT_COUNT_EN
    ,
    output logic [7:0] fork_count
`endif
);

    localparam int PW = $clog2(TICK_DIV + 1);
    localparam int DW = $clog2(STABLE_CNT + 1);
    localparam int HW = (HOLDOFF_TICKS > 0) ? $clog2(HOLDOFF_TICKS + 1) : 1;

    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(STABLE_CNT - 1);
    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLDOFF_TICKS);

    typedef enum logic [1:0] {IDLE, BLANK, TRACK, HOLD} state_t;

    state_t        state;
    state_t        next_state;
    logic [PW-1:0] pre_cnt;
    logic          tick;
    logic [DW-1:0] db_cnt [4];
    logic [HW-1:0] hold_cnt;
    logic          junction;

    assign tick = (pre_cnt == PRE_LAST);

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PW'(1);
        end
    end

    // Any tick where raw agrees with stable restarts that bit's run.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            det_stable <= '0;
            // NOTE: db_cnt is four small flops, not a RAM, so clearing it in reset is cheap and safe.
            for (int i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else if (tick) begin
            for (int i = 0; i < 4; i++) begin
                if (det_raw[i] == det_stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    det_stable[i] <= det_raw[i];
                    db_cnt[i]     <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DW'(1);
                end
            end
        end
    end

    // Plain corridor is front open with both sides blocked; back is ignored.
    assign junction = !(!det_stable[3] && det_stable[1] && det_stable[0]);

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            hold_cnt <= '0;
        end else if (state == IDLE && arm) begin
            hold_cnt <= HOLD_INIT;
        end else if (state == BLANK && tick && hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HW'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state is defaulted first so no path through the case infers a latch.
    always_comb begin
        next_state = state;
        if (!arm) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    next_state = (HOLDOFF_TICKS == 0) ? TRACK : BLANK;
                BLANK:   if (hold_cnt == '0) next_state = TRACK;
                TRACK:   if (junction) next_state = HOLD;
                HOLD:    next_state = HOLD;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        fork_level     = (state == HOLD);
        holdoff_active = (state == BLANK);
    end

    // The pulse is registered so it lands in the first HOLD cycle only.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            fork_pulse <= 1'b0;
        end else begin
            fork_pulse <= (state == TRACK) && (next_state == HOLD);
        end
    end

`ifdef FORK_EVENT_COUNT_EN
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            fork_count <= '0;
        end else if (fork_pulse && fork_count != 8'hFF) begin
            fork_count <= fork_count + 8'd1;
        end
    end
`endif

endmodule
